snake_game_engine: RTL and testbench

//  Parametrised snake game core: key-driven game FSM, grid-based snake of variable length
//  (grows on food), wall/self collision, LFSR food placement, score, and per-pixel colour.

---
 rtl/snake_game_if.sv | 52 +++++
 rtl/snake_game_engine.sv | 275 +++++++++++++++++++++++++++
 tb/tb_snake_game_engine.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/snake_game_if.sv
// Snake game engine bus.
// Groups the per-pixel, key and tick signals between the game core and its
// neighbours (PS/2 decoder, tick generator, VGA timing), plus a small debug
// view of the snake head, length and food so checkers can bind to it.
//
// Handshake: new_key_strobe is a one-cycle valid qualifying keycode. There is
// no ready; the engine accepts every strobe in the cycle it is asserted.
// tick is a one-cycle step enable with the same always-accept rule.
//
// Signals (direction as seen by the engine, modport slave):
//   tick            in   game-step enable
//   new_key_strobe  in   keycode valid
//   keycode[7:0]    in   PS/2 make code
//   hcount/vcount   in   current VGA pixel (11 bits each)
//   color[7:0]      out  RGB332 pixel colour, registered
//   game_state[2:0] out  0 IDLE, 1 READY, 2 PLAY, 3 PAUSED, 4 OVER
//   score[7:0]      out  food eaten since start, saturating
//   dbg_*           out  head cell, length, food cell and food valid
interface snake_game_if #(
  parameter int CW = 7,
  parameter int RW = 6,
  parameter int LW = 5
);
  logic          tick;
  logic          new_key_strobe;
  logic [7:0]    keycode;
  logic [10:0]   hcount;
  logic [10:0]   vcount;
  logic [7:0]    color;
  logic [2:0]    game_state;
  logic [7:0]    score;
  logic [CW-1:0] dbg_head_col;
  logic [RW-1:0] dbg_head_row;
  logic [LW-1:0] dbg_length;
  logic [CW-1:0] dbg_food_col;
  logic [RW-1:0] dbg_food_row;
  logic          dbg_food_valid;

  modport master (
    output tick, new_key_strobe, keycode, hcount, vcount,
    input  color, game_state, score,
    input  dbg_head_col, dbg_head_row, dbg_length,
    input  dbg_food_col, dbg_food_row, dbg_food_valid
  );

  modport slave (
    input  tick, new_key_strobe, keycode, hcount, vcount,
    output color, game_state, score,
    output dbg_head_col, dbg_head_row, dbg_length,
    output dbg_food_col, dbg_food_row, dbg_food_valid
  );
endinterface

// File: rtl/snake_game_engine.sv
// Snake game core: key-driven game FSM, grid snake that grows on food,
// wall/self collision, LFSR food placement, score and per-pixel colour.
// Everything runs on clk_25MHz; game steps happen on the one-cycle tick.
//
// Ports:
//   clk_25MHz  system and pixel clock
//   reset      synchronous, active-high
//   bus        snake_game_if.slave (tick, keys, pixel in; colour, state,
//              score and debug view out)
module snake_game_engine #(
  parameter int          CELL_LOG2 = 3,
  parameter int          H_RES     = 640,
  parameter int          V_RES     = 480,
  parameter int          MAX_LEN   = 16,
  parameter int          INIT_LEN  = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk_25MHz,
  input  logic       reset,
  snake_game_if.slave bus
);
  localparam int COLS = H_RES >> CELL_LOG2;
  localparam int ROWS = V_RES >> CELL_LOG2;
  localparam int CW   = $clog2(COLS);
  localparam int RW   = $clog2(ROWS);
  localparam int LW   = $clog2(MAX_LEN + 1);

  localparam logic [7:0] KEY_ESC   = 8'h76;
  localparam logic [7:0] KEY_S     = 8'h1B;
  localparam logic [7:0] KEY_P     = 8'h4D;
  localparam logic [7:0] KEY_R     = 8'h2D;
  localparam logic [7:0] KEY_UP    = 8'h75;
  localparam logic [7:0] KEY_RIGHT = 8'h74;
  localparam logic [7:0] KEY_DOWN  = 8'h72;
  localparam logic [7:0] KEY_LEFT  = 8'h6B;

  // Opposite directions differ only in bit 0, so reversal is d ^ 1.
  localparam logic [1:0] D_RIGHT = 2'd0;
  localparam logic [1:0] D_LEFT  = 2'd1;
  localparam logic [1:0] D_UP    = 2'd2;
  localparam logic [1:0] D_DOWN  = 2'd3;

  localparam logic [6:0] CAND_COL_MAX = 7'(COLS - 2);
  localparam logic [5:0] CAND_ROW_MAX = 6'(ROWS - 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READY  = 3'd1,
    S_PLAY   = 3'd2,
    S_PAUSED = 3'd3,
    S_OVER   = 3'd4
  } state_t;

  state_t        r_state;
  logic [1:0]    r_dir;
  logic [1:0]    r_pend_dir;
  logic [LW-1:0] r_len;
  logic [CW-1:0] r_seg_col [MAX_LEN];
  logic [RW-1:0] r_seg_row [MAX_LEN];
  logic [CW-1:0] r_food_col;
  logic [RW-1:0] r_food_row;
  logic          r_food_valid;
  logic [15:0]   r_lfsr;
  logic [7:0]    r_score;
  logic [7:0]    r_color;

  function automatic logic [CW-1:0] init_col(input int i);
    return (i < INIT_LEN) ? CW'(INIT_LEN + 1 - i) : '0;
  endfunction

  function automatic logic [RW-1:0] init_row(input int i);
    return (i < INIT_LEN) ? RW'(2) : '0;
  endfunction

  // ---------------- step evaluation ----------------
  logic [CW-1:0] w_next_col;
  logic [RW-1:0] w_next_row;
  logic          w_step;
  logic          w_border_next;
  logic          w_eat;
  logic          w_grow;
  logic          w_hit_body;
  logic          w_collide;
  logic          w_move;
  state_t        w_state_t;
  logic [1:0]    w_dir_t;

  always_comb begin
    w_next_col = r_seg_col[0];
    w_next_row = r_seg_row[0];
    case (r_pend_dir)
      D_RIGHT: w_next_col = r_seg_col[0] + CW'(1);
      D_LEFT:  w_next_col = r_seg_col[0] - CW'(1);
      D_UP:    w_next_row = r_seg_row[0] - RW'(1);
      default: w_next_row = r_seg_row[0] + RW'(1);
    endcase
  end

  assign w_step        = bus.tick && (r_state == S_PLAY);
  assign w_border_next = (w_next_col == CW'(0)) || (w_next_col == CW'(COLS - 1)) ||
                         (w_next_row == RW'(0)) || (w_next_row == RW'(ROWS - 1));
  assign w_eat         = r_food_valid && (w_next_col == r_food_col) && (w_next_row == r_food_row);
  assign w_grow        = w_eat && (r_len < LW'(MAX_LEN));

  // ---------------- food candidate ----------------
  logic [6:0] w_cand_col;
  logic [5:0] w_cand_row;
  logic       w_cand_in_range;
  logic       w_cand_on_snake;

  assign w_cand_col      = r_lfsr[6:0];
  assign w_cand_row      = r_lfsr[13:8];
  assign w_cand_in_range = (w_cand_col >= 7'd1) && (w_cand_col <= CAND_COL_MAX) &&
                           (w_cand_row >= 6'd1) && (w_cand_row <= CAND_ROW_MAX);

  // ---------------- pixel classification ----------------
  logic [10:0] w_px_col;
  logic [10:0] w_px_row;
  logic        w_px_visible;
  logic        w_px_border;
  logic        w_px_head;
  logic        w_px_body;
  logic        w_px_food;
  logic [7:0]  w_color_n;

  assign w_px_col     = bus.hcount >> CELL_LOG2;
  assign w_px_row     = bus.vcount >> CELL_LOG2;
  assign w_px_visible = (bus.hcount < 11'(H_RES)) && (bus.vcount < 11'(V_RES));
  assign w_px_border  = (w_px_col == 11'd0) || (w_px_col == 11'(COLS - 1)) ||
                        (w_px_row == 11'd0) || (w_px_row == 11'(ROWS - 1));
  assign w_px_head    = (w_px_col == 11'(r_seg_col[0])) && (w_px_row == 11'(r_seg_row[0]));
  assign w_px_food    = r_food_valid && (w_px_col == 11'(r_food_col)) &&
                        (w_px_row == 11'(r_food_row));

  // Segment scans: only indices below the live length count. The tail is
  // exempt from self collision when it is about to move away (no growth).
  always_comb begin
    w_hit_body      = 1'b0;
    w_cand_on_snake = 1'b0;
    w_px_body       = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (LW'(i) < r_len) begin
        if ((r_seg_col[i] == w_next_col) && (r_seg_row[i] == w_next_row) &&
            (w_grow || (LW'(i) != r_len - LW'(1))))
          w_hit_body = 1'b1;
        if ((r_seg_col[i] == CW'(w_cand_col)) && (r_seg_row[i] == RW'(w_cand_row)))
          w_cand_on_snake = 1'b1;
        if ((i > 0) && (w_px_col == 11'(r_seg_col[i])) && (w_px_row == 11'(r_seg_row[i])))
          w_px_body = 1'b1;
      end
    end
  end

  assign w_collide = w_step && (w_border_next || w_hit_body);
  assign w_move    = w_step && !w_collide;

  // Keys are applied on top of whatever this cycle's tick produced.
  assign w_state_t = w_collide ? S_OVER : r_state;
  assign w_dir_t   = w_step ? r_pend_dir : r_dir;

  logic       w_key_is_arrow;
  logic [1:0] w_key_dir;
  logic       w_key_rev;

  always_comb begin
    w_key_is_arrow = 1'b1;
    w_key_dir      = D_RIGHT;
    case (bus.keycode)
      KEY_RIGHT: w_key_dir = D_RIGHT;
      KEY_LEFT:  w_key_dir = D_LEFT;
      KEY_UP:    w_key_dir = D_UP;
      KEY_DOWN:  w_key_dir = D_DOWN;
      default:   w_key_is_arrow = 1'b0;
    endcase
  end

  assign w_key_rev = (w_key_dir == (w_dir_t ^ 2'b01));

  always_comb begin
    w_color_n = 8'h00;
    if (w_px_visible && (r_state != S_IDLE)) begin
      if (w_px_border)    w_color_n = 8'hE0;
      else if (w_px_head) w_color_n = 8'h1C;
      else if (w_px_body) w_color_n = 8'h03;
      else if (w_px_food) w_color_n = 8'hFC;
      else                w_color_n = (r_state == S_OVER) ? 8'h49 : 8'hFF;
    end
  end

  // ---------------- state ----------------
  always_ff @(posedge clk_25MHz) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_dir        <= D_RIGHT;
      r_pend_dir   <= D_RIGHT;
      r_len        <= LW'(INIT_LEN);
      for (int i = 0; i < MAX_LEN; i++) begin
        r_seg_col[i] <= init_col(i);
        r_seg_row[i] <= init_row(i);
      end
      r_food_col   <= CW'(COLS / 2);
      r_food_row   <= RW'(ROWS / 2);
      r_food_valid <= 1'b1;
      r_lfsr       <= LFSR_SEED;
      r_score      <= 8'd0;
      r_color      <= 8'h00;
    end else begin
      r_color <= w_color_n;
      // x^16 + x^14 + x^13 + x^11, shifting left
      r_lfsr  <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};

      if (!r_food_valid && w_cand_in_range && !w_cand_on_snake) begin
        r_food_col   <= CW'(w_cand_col);
        r_food_row   <= RW'(w_cand_row);
        r_food_valid <= 1'b1;
      end

      if (w_collide) r_state <= S_OVER;
      if (w_step)    r_dir   <= r_pend_dir;
      if (w_move) begin
        for (int i = MAX_LEN - 1; i > 0; i--) begin
          r_seg_col[i] <= r_seg_col[i-1];
          r_seg_row[i] <= r_seg_row[i-1];
        end
        r_seg_col[0] <= w_next_col;
        r_seg_row[0] <= w_next_row;
        if (w_eat) begin
          if (w_grow) r_len <= r_len + LW'(1);
          if (r_score != 8'hFF) r_score <= r_score + 8'd1;
          r_food_valid <= 1'b0;
        end
      end

      if (bus.new_key_strobe) begin
        if (bus.keycode == KEY_ESC) begin
          r_state <= S_IDLE;
        end else if ((bus.keycode == KEY_S) &&
                     ((w_state_t == S_IDLE) || (w_state_t == S_PAUSED) || (w_state_t == S_OVER))) begin
          r_state    <= S_READY;
          r_dir      <= D_RIGHT;
          r_pend_dir <= D_RIGHT;
          r_len      <= LW'(INIT_LEN);
          r_score    <= 8'd0;
          for (int i = 0; i < MAX_LEN; i++) begin
            r_seg_col[i] <= init_col(i);
            r_seg_row[i] <= init_row(i);
          end
        end else if ((bus.keycode == KEY_R) &&
                     ((w_state_t == S_READY) || (w_state_t == S_PAUSED))) begin
          r_state <= S_PLAY;
        end else if ((w_state_t == S_READY) && w_key_is_arrow) begin
          r_state <= S_PLAY;
          if (!w_key_rev) begin
            r_dir      <= w_key_dir;
            r_pend_dir <= w_key_dir;
          end
        end else if ((w_state_t == S_PLAY) && (bus.keycode == KEY_P)) begin
          r_state <= S_PAUSED;
        end else if ((w_state_t == S_PLAY) && w_key_is_arrow && !w_key_rev) begin
          r_pend_dir <= w_key_dir;
        end
      end
    end
  end

  assign bus.color          = r_color;
  assign bus.game_state     = r_state;
  assign bus.score          = r_score;
  assign bus.dbg_head_col   = r_seg_col[0];
  assign bus.dbg_head_row   = r_seg_row[0];
  assign bus.dbg_length     = r_len;
  assign bus.dbg_food_col   = r_food_col;
  assign bus.dbg_food_row   = r_food_row;
  assign bus.dbg_food_valid = r_food_valid;
endmodule

// File: tb/tb_snake_game_engine.sv
// Bench for snake_game_engine: reference snake model (queue of cells),
// pixel scoreboard with an expected-colour queue, and a table of pixel vectors.
module tb_snake_game_engine;
  localparam logic [7:0] K_ESC = 8'h76, K_S = 8'h1B, K_P = 8'h4D, K_R = 8'h2D;
  localparam logic [7:0] K_UP = 8'h75, K_RIGHT = 8'h74, K_DOWN = 8'h72, K_LEFT = 8'h6B;

  logic clk = 1'b0;
  logic rst = 1'b1;
  snake_game_if bus ();

  snake_game_engine dut (
    .clk_25MHz (clk),
    .reset     (rst),
    .bus       (bus)
  );

  always #20 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  // model: cells head first; dirs 0 right, 1 left, 2 up (row-1), 3 down
  int mc[$];
  int mr[$];
  int m_state, m_dir, m_pend, m_score, m_fc, m_fr;
  bit m_fv;

  typedef struct {
    int         hc;
    int         vc;
    logic [7:0] exp;
  } pix_vec_t;
  pix_vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void m_load_snake();
    mc.delete(); mr.delete();
    for (int i = 0; i < 4; i++) begin
      mc.push_back(5 - i);
      mr.push_back(2);
    end
    m_dir = 0; m_pend = 0; m_score = 0;
  endfunction

  function automatic void m_reset();
    m_load_snake();
    m_state = 0;
    m_fc = 40; m_fr = 30; m_fv = 1'b1;
  endfunction

  function automatic void m_tick();
    int nc, nr;
    bit eat, grow, hit;
    if (m_state != 2) return;
    m_dir = m_pend;
    nc = mc[0]; nr = mr[0];
    case (m_dir)
      0: nc++;
      1: nc--;
      2: nr--;
      default: nr++;
    endcase
    eat  = m_fv && (nc == m_fc) && (nr == m_fr);
    grow = eat && (mc.size() < 16);
    hit  = (nc == 0) || (nc == 79) || (nr == 0) || (nr == 59);
    for (int i = 0; i < mc.size(); i++)
      if (mc[i] == nc && mr[i] == nr && (grow || i != mc.size() - 1)) hit = 1'b1;
    if (hit) begin
      m_state = 4;
      return;
    end
    mc.push_front(nc); mr.push_front(nr);
    if (!grow) begin
      void'(mc.pop_back());
      void'(mr.pop_back());
    end
    if (eat) begin
      if (m_score < 255) m_score++;
      m_fv = 1'b0;
    end
  endfunction

  function automatic void m_key(input logic [7:0] k);
    int d;
    case (k)
      K_RIGHT: d = 0;
      K_LEFT:  d = 1;
      K_UP:    d = 2;
      K_DOWN:  d = 3;
      default: d = -1;
    endcase
    if (k == K_ESC) m_state = 0;
    else if (k == K_S && (m_state == 0 || m_state == 3 || m_state == 4)) begin
      m_load_snake();
      m_state = 1;
    end else if (k == K_R && (m_state == 1 || m_state == 3)) m_state = 2;
    else if (m_state == 1 && d >= 0) begin
      m_state = 2;
      if (d != (m_dir ^ 1)) begin m_dir = d; m_pend = d; end
    end else if (m_state == 2 && k == K_P) m_state = 3;
    else if (m_state == 2 && d >= 0 && d != (m_dir ^ 1)) m_pend = d;
  endfunction

  function automatic logic [7:0] exp_color(input int hc, input int vc);
    int c, r;
    if (hc >= 640 || vc >= 480 || m_state == 0) return 8'h00;
    c = hc >> 3; r = vc >> 3;
    if (c == 0 || c == 79 || r == 0 || r == 59) return 8'hE0;
    if (c == mc[0] && r == mr[0]) return 8'h1C;
    for (int i = 1; i < mc.size(); i++)
      if (c == mc[i] && r == mr[i]) return 8'h03;
    if (m_fv && c == m_fc && r == m_fr) return 8'hFC;
    return (m_state == 4) ? 8'h49 : 8'hFF;
  endfunction

  task automatic check_snake(input string tag);
    check({tag, " state"}, 32'(bus.game_state), m_state);
    check({tag, " head_col"}, 32'(bus.dbg_head_col), mc[0]);
    check({tag, " head_row"}, 32'(bus.dbg_head_row), mr[0]);
    check({tag, " length"}, 32'(bus.dbg_length), mc.size());
    check({tag, " score"}, 32'(bus.score), m_score);
  endtask

  task automatic key(input logic [7:0] k);
    bus.new_key_strobe = 1'b1; bus.keycode = k;
    @(posedge clk); #1;
    bus.new_key_strobe = 1'b0; bus.keycode = 8'h00;
    m_key(k);
    check_snake($sformatf("key %02h", k));
  endtask

  task automatic tick();
    bus.tick = 1'b1;
    @(posedge clk); #1;
    bus.tick = 1'b0;
    m_tick();
    check_snake("tick");
  endtask

  task automatic tick_key(input logic [7:0] k);
    bus.tick = 1'b1; bus.new_key_strobe = 1'b1; bus.keycode = k;
    @(posedge clk); #1;
    bus.tick = 1'b0; bus.new_key_strobe = 1'b0; bus.keycode = 8'h00;
    m_tick();
    m_key(k);
    check_snake("tick+key");
  endtask

  task automatic pix(input int hc, input int vc, input logic [7:0] e);
    logic [7:0] want;
    bus.hcount = 11'(hc); bus.vcount = 11'(vc);
    exp_q.push_back(e);
    @(posedge clk); #1;
    want = exp_q.pop_front();
    check($sformatf("color(%0d,%0d)", hc, vc), 32'(bus.color), 32'(want));
  endtask

  task automatic wait_food();
    int n;
    bit on;
    int fc, fr;
    n = 0;
    while (bus.dbg_food_valid !== 1'b1 && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    check("food_revalid", 32'(bus.dbg_food_valid), 1);
    fc = int'(bus.dbg_food_col); fr = int'(bus.dbg_food_row);
    check("food_in_range", 32'((fc >= 1 && fc <= 78 && fr >= 1 && fr <= 58)), 1);
    on = 1'b0;
    for (int i = 0; i < mc.size(); i++) if (mc[i] == fc && mr[i] == fr) on = 1'b1;
    check("food_off_snake", 32'(on), 0);
    m_fc = fc; m_fr = fr; m_fv = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{40, 16, 8'h1C};   // head (5,2)
    vecs[1]  = '{47, 23, 8'h1C};   // head cell, far corner
    vecs[2]  = '{32, 16, 8'h03};   // body (4,2)
    vecs[3]  = '{16, 16, 8'h03};   // tail (2,2)
    vecs[4]  = '{8, 16, 8'hFF};    // (1,2) background
    vecs[5]  = '{320, 240, 8'hFC}; // food (40,30)
    vecs[6]  = '{0, 0, 8'hE0};
    vecs[7]  = '{639, 479, 8'hE0};
    vecs[8]  = '{632, 100, 8'hE0};
    vecs[9]  = '{640, 0, 8'h00};   // outside visible area
    vecs[10] = '{0, 480, 8'h00};
    vecs[11] = '{100, 100, 8'hFF};

    bus.tick = 1'b0; bus.new_key_strobe = 1'b0; bus.keycode = 8'h00;
    bus.hcount = 11'd0; bus.vcount = 11'd0;
    m_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset values
    check_snake("reset");
    check("reset color", 32'(bus.color), 0);
    check("reset food_col", 32'(bus.dbg_food_col), 40);
    check("reset food_row", 32'(bus.dbg_food_row), 30);
    check("reset food_valid", 32'(bus.dbg_food_valid), 1);
    pix(40, 16, 8'h00);

    // READY: tick does nothing, snake drawn
    key(K_S);
    tick();
    check("ready head_col", 32'(bus.dbg_head_col), 5);
    check("ready length", 32'(bus.dbg_length), 4);
    for (int i = 0; i < 12; i++) pix(vecs[i].hc, vecs[i].vc, vecs[i].exp);

    // PLAY, reversal ignored
    key(K_R);
    repeat (3) tick();
    check("play head_col", 32'(bus.dbg_head_col), 8);
    key(K_LEFT);
    tick();
    check("reverse ignored head_col", 32'(bus.dbg_head_col), 9);

    // route to the food at (40,30) and eat it
    key(K_DOWN);
    repeat (28) tick();
    key(K_RIGHT);
    repeat (31) tick();
    check("eat length", 32'(bus.dbg_length), 5);
    check("eat score", 32'(bus.score), 1);
    check("eat food_valid", 32'(bus.dbg_food_valid), 0);
    wait_food();

    // curl into own body
    key(K_DOWN);  tick();
    key(K_LEFT);  tick();
    key(K_UP);    tick();
    check("self hit state", 32'(bus.game_state), 4);
    check("self hit head_row", 32'(bus.dbg_head_row), 31);
    pix(100, 100, exp_color(100, 100));
    pix(39 * 8, 31 * 8, exp_color(39 * 8, 31 * 8));
    pix(40 * 8, 31 * 8, exp_color(40 * 8, 31 * 8));

    // restart, chase the departing tail, then hit the right wall
    key(K_S);
    check("restart score", 32'(bus.score), 0);
    check("restart length", 32'(bus.dbg_length), 4);
    key(K_R);
    key(K_DOWN);  tick();
    key(K_LEFT);  tick();
    key(K_UP);    tick();
    check("tail chase state", 32'(bus.game_state), 2);
    key(K_RIGHT); tick();
    repeat (73) tick();
    check("pre-wall head_col", 32'(bus.dbg_head_col), 78);
    tick();
    check("wall state", 32'(bus.game_state), 4);
    check("wall head_col", 32'(bus.dbg_head_col), 78);
    key(K_S);
    check("wall restart length", 32'(bus.dbg_length), 4);

    // pause holds the snake; same-cycle tick+p steps first
    key(K_R);
    tick();
    key(K_P);
    repeat (5) tick();
    check("paused head_col", 32'(bus.dbg_head_col), 6);
    key(K_R);
    tick_key(K_P);
    check("tick+p head_col", 32'(bus.dbg_head_col), 7);
    check("tick+p state", 32'(bus.game_state), 3);
    key(K_R);
    key(K_ESC);
    for (int i = 0; i < 12; i++) pix(vecs[i].hc, vecs[i].vc, 8'h00);

    // reset in the middle of play
    key(K_S);
    key(K_R);
    tick();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_reset();
    check_snake("mid-play reset");
    pix(40, 16, 8'h00);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
